mmio_bridge: RTL
================

# mmio_bridge

Memory-mapped I/O bridge directly downstream of the pipelined MIPS core's memory stage. It consumes the core's M-stage data address, write data and write enable. It returns the read data the core latches into W. It steers each access to the external data RAM, a down-counting interval timer, or the GPIO registers.

## Interface
Parameters:
- GPO_W, 16: width of general-purpose output register (1..32)
- GPI_W, 16: width of general-purpose input port (1..32)
- PRESCALE, 1: clk cycles per timer tick (≥1)

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- addr  in  32  byte address from core (M-stage ALU result)
- wd  in  32  store data from core
- we  in  1  store enable from core
- rd_dm  out  32  load data to core, combinational, valid same cycle
- dm_rd  in  32  read data from external data RAM
- dm_we  out  1  write enable to external data RAM
- gpi  in  GPI_W  asynchronous external inputs
- gpo  out  GPO_W  registered external outputs
- irq  out  1  timer interrupt, level

## Operation
- Decode uses addr[31:2]; addr[1:0] ignored (word access only).
- DMEM region: addr < 0x0000_1000. dm_we = we; rd_dm = dm_rd.
- TIMER region registers:
  - 0x1000 CTRL: bit0 EN, bit1 RELOAD, bit2 IRQ_EN; other bits read 0.
  - 0x1004 LOAD: 32-bit reload value, R/W.
  - 0x1008 COUNT: current count. A write loads the count directly.
  - 0x100C STATUS: bit0 EXPIRED, sticky. A write of 1 to bit0 clears it.
- GPIO region registers:
  - 0x1100 GPO: R/W, low GPO_W bits; read zero-extends.
  - 0x1104 GPI: read-only. Returns the 2-flop-synchronised gpi, zero-extended. Writes are ignored.
- Any other address: reads return 0, writes ignored, dm_we = 0.
- dm_we is 0 whenever addr is outside DMEM, regardless of we.
- Prescaler:
  - While EN=1, it counts 0..PRESCALE-1 and asserts tick on the terminal value.
  - It resets to 0 when EN=0 or when CTRL is written.
- On tick:
  - COUNT>1: COUNT decrements.
  - COUNT==1: COUNT ← LOAD if RELOAD=1, else 0. EXPIRED ← 1 in either case.
  - COUNT==0: COUNT holds, no EXPIRED event.
- irq = EXPIRED & IRQ_EN.

## Timing
- Reset values:
  - CTRL, LOAD, COUNT, EXPIRED, GPO, prescaler and both synchroniser stages reset to 0.
  - As a result, gpo=0 and irq=0.
- Reset mid-operation clears all state immediately (asynchronous). The first tick after release is no earlier than PRESCALE cycles after EN is set.
- Register writes take effect at the clock edge where we=1. Readback is visible on rd_dm the following cycle.
- Reads are zero-latency (combinational from addr), matching the core's single-cycle M stage. No stall or handshake exists.
- gpi change reaches the GPI read value 2 clk edges later.
- With PRESCALE=1, COUNT=N and EN=1, EXPIRED rises N cycles after EN is written.
- Simultaneous events:
  - A software COUNT write beats a tick decrement in the same cycle.
  - A tick setting EXPIRED beats a STATUS clear in the same cycle, so EXPIRED stays 1.
  - A LOAD write in the same cycle as a reload tick: COUNT takes the old LOAD.

## Structure
- Package mmio_pkg holds:
  - region base constants DMEM_LIMIT, TIMER_BASE, GPIO_BASE
  - register offset constants
  - CTRL bit-index constants
  - an enum for the decoded region (REG_DMEM, REG_TIMER, REG_GPIO, REG_NONE)
- Sub-module mmio_timer holds the prescaler, COUNT, LOAD, CTRL and STATUS logic.
- The top level holds decode, the read mux, the GPIO registers and the GPI synchroniser.

## Test plan
- DMEM access:
  - Stimulus: addr=0x0000_0FFC, we=1, then addr=0x0000_1000, we=1.
  - Required: dm_we=1 for the first access, 0 for the second. rd_dm equals dm_rd=0xDEAD_BEEF while addr is in DMEM.
- GPIO:
  - Stimulus: write 0xFFFF_A5A5 to 0x1100, then read it back.
  - Required: gpo=16'hA5A5, readback 0x0000_A5A5.
  - Stimulus: drive gpi=16'h1234.
  - Required: read of 0x1104 returns 0x0000_1234 from the third cycle.
- One-shot timer:
  - Stimulus: PRESCALE=1; write COUNT=3; write CTRL=0x5.
  - Required: EXPIRED=1 and irq=1 exactly 3 cycles after the CTRL write. COUNT then holds 0.
- Auto-reload:
  - Stimulus: LOAD=2, COUNT=2, CTRL=0x3, PRESCALE=4.
  - Required: COUNT sequence 2,1,2,1… changing every 4 cycles. EXPIRED is set on each 1→reload tick.
- Collision cases:
  - Stimulus: STATUS clear in the same cycle as an expiring tick.
  - Required: EXPIRED remains 1.
  - Stimulus: COUNT write of 7 in a tick cycle.
  - Required: COUNT=7.
- Reset and unmapped access:
  - Stimulus: assert rst low mid-count.
  - Required: all registers, gpo and irq read 0 immediately.
  - Stimulus: read of 0x2000.
  - Required: returns 0.

Source files
------------

// File: rtl/mmio_pkg.sv
// Shared address map, register indices and region decode for the MMIO bridge.
package mmio_pkg;

    localparam logic [31:0] DMEM_LIMIT = 32'h0000_1000;
    localparam logic [31:0] TIMER_BASE = 32'h0000_1000;
    localparam logic [31:0] GPIO_BASE  = 32'h0000_1100;

    // Register offsets expressed as word indices inside each block.
    localparam logic [1:0] TMR_CTRL   = 2'd0;
    localparam logic [1:0] TMR_LOAD   = 2'd1;
    localparam logic [1:0] TMR_COUNT  = 2'd2;
    localparam logic [1:0] TMR_STATUS = 2'd3;
    localparam logic       GPIO_GPO   = 1'b0;
    localparam logic       GPIO_GPI   = 1'b1;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_RELOAD = 1;
    localparam int CTRL_IRQ_EN = 2;

    typedef enum logic [1:0] {
        REG_DMEM  = 2'd0,
        REG_TIMER = 2'd1,
        REG_GPIO  = 2'd2,
        REG_NONE  = 2'd3
    } region_e;

    // Word-granular decode; the byte-lane bits never reach this function.
    function automatic region_e decode_region(input logic [31:2] word);
        if ({word, 2'b00} < DMEM_LIMIT)       return REG_DMEM;
        if (word[31:4] == TIMER_BASE[31:4])   return REG_TIMER;
        if (word[31:3] == GPIO_BASE[31:3])    return REG_GPIO;
        return REG_NONE;
    endfunction

endpackage

// File: rtl/mmio_timer.sv
// Down-counting interval timer: prescaler, CTRL, LOAD, COUNT and sticky EXPIRED.
module mmio_timer
    import mmio_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr,
    input  logic [1:0]  wr_sel,
    input  logic [31:0] wd,
    output logic [2:0]  ctrl,
    output logic [31:0] load,
    output logic [31:0] count,
    output logic        expired,
    output logic        irq
);

    localparam int              PS_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_TC = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0] pre;
    logic            wr_ctrl;
    logic            wr_load;
    logic            wr_count;
    logic            wr_status;
    logic            tick;

    assign wr_ctrl   = wr && (wr_sel == TMR_CTRL);
    assign wr_load   = wr && (wr_sel == TMR_LOAD);
    assign wr_count  = wr && (wr_sel == TMR_COUNT);
    assign wr_status = wr && (wr_sel == TMR_STATUS);

    // A CTRL write restarts the prescale period, so it also swallows any tick that cycle.
    assign tick = ctrl[CTRL_EN] && (pre == PS_TC) && !wr_ctrl;
    assign irq  = expired && ctrl[CTRL_IRQ_EN];

    // Prescaler: free-runs 0..PRESCALE-1 while enabled, parked at 0 otherwise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre <= '0;
        end else if (!ctrl[CTRL_EN] || wr_ctrl || (pre == PS_TC)) begin
            pre <= '0;
        end else begin
            pre <= pre + PS_W'(1);
        end
    end

    // Software-visible configuration registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl <= '0;
            load <= '0;
        end else begin
            if (wr_ctrl) ctrl <= wd[2:0];
            if (wr_load) load <= wd;
        end
    end

    // Counter: a software write wins over the tick; reload uses LOAD before any same-cycle write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (wr_count) begin
            count <= wd;
        end else if (tick) begin
            if (count > 32'd1)       count <= count - 32'd1;
            else if (count == 32'd1) count <= ctrl[CTRL_RELOAD] ? load : 32'd0;
        end
    end

    // Sticky expiry flag: the expiring tick has priority over a write-1-to-clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            expired <= 1'b0;
        end else if (tick && (count == 32'd1)) begin
            expired <= 1'b1;
        end else if (wr_status && wd[0]) begin
            expired <= 1'b0;
        end
    end

endmodule

// File: rtl/mmio_bridge.sv
// M-stage MMIO bridge: steers core accesses to data RAM, the timer or GPIO.
module mmio_bridge
    import mmio_pkg::*;
#(
    parameter int GPO_W    = 16,
    parameter int GPI_W    = 16,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      addr,
    input  logic [31:0]      wd,
    input  logic             we,
    output logic [31:0]      rd_dm,
    input  logic [31:0]      dm_rd,
    output logic             dm_we,
    input  logic [GPI_W-1:0] gpi,
    output logic [GPO_W-1:0] gpo,
    output logic             irq
);

    region_e          region;
    logic [2:0]       tmr_ctrl;
    logic [31:0]      tmr_load;
    logic [31:0]      tmr_count;
    logic             tmr_expired;
    logic [GPI_W-1:0] gpi_s1;
    logic [GPI_W-1:0] gpi_s2;
    logic             unused_addr_lo;

    // Word access only: byte-lane bits are deliberately ignored.
    assign unused_addr_lo = ^addr[1:0];
    assign region         = decode_region(addr[31:2]);
    assign dm_we          = we && (region == REG_DMEM);

    mmio_timer #(
        .PRESCALE (PRESCALE)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .wr      (we && (region == REG_TIMER)),
        .wr_sel  (addr[3:2]),
        .wd      (wd),
        .ctrl    (tmr_ctrl),
        .load    (tmr_load),
        .count   (tmr_count),
        .expired (tmr_expired),
        .irq     (irq)
    );

    // General-purpose output register; the GPI slot ignores writes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gpo <= '0;
        end else if (we && (region == REG_GPIO) && (addr[2] == GPIO_GPO)) begin
            gpo <= wd[GPO_W-1:0];
        end
    end

    // Two-flop synchroniser for the asynchronous input pins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gpi_s1 <= '0;
            gpi_s2 <= '0;
        end else begin
            gpi_s1 <= gpi;
            gpi_s2 <= gpi_s1;
        end
    end

    // Zero-latency read mux feeding the core's W-stage latch.
    always_comb begin
        rd_dm = '0;
        case (region)
            REG_DMEM: rd_dm = dm_rd;
            REG_TIMER: begin
                case (addr[3:2])
                    TMR_CTRL:   rd_dm = 32'(tmr_ctrl);
                    TMR_LOAD:   rd_dm = tmr_load;
                    TMR_COUNT:  rd_dm = tmr_count;
                    TMR_STATUS: rd_dm = 32'(tmr_expired);
                    default:    rd_dm = '0;
                endcase
            end
            REG_GPIO: rd_dm = (addr[2] == GPIO_GPI) ? 32'(gpi_s2) : 32'(gpo);
            default:  rd_dm = '0;
        endcase
    end

endmodule
